voice_allocator: RTL and testbench

- Writer side of the synthesizer's per-channel word bus. It accepts note-on and note-off events over a valid/ready handshake and assigns each one to a channel.
- Maintains the packed carrier and modulator word banks that the channel sequencer reads, together with the per-channel available vector.
- Sits between the host/MIDI event decoder and the FM channel sequencer.

---
 rtl/voice_allocator.sv | 262 ++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//   Writer side of the per-channel word bus. Accepts note-on / note-off events
//   over a valid/ready handshake, picks a channel in a three-state pipeline
//   (IDLE -> SEARCH -> WRITE) and maintains the packed carrier/modulator word
//   banks, the per-channel available vector and the active-voice count.
//
//   Optional build macro: VOICE_STEAL_EN
//     defined   : a note-on with every channel busy steals the channel under a
//                 round-robin pointer (drop still pulses to flag the steal).
//     undefined : a note-on with every channel busy is discarded.
// ---------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_BITS     = 32,
    parameter int NUM_CHANNELS = 16,
    parameter int KEY_BITS     = 7
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 evt_valid,
    output logic                                 evt_ready,
    input  logic                                 evt_on,
    input  logic [KEY_BITS-1:0]                  evt_key,
    input  logic [NUM_BITS-2:0]                  evt_car,
    input  logic [NUM_BITS-1:0]                  evt_mod,
    input  logic                                 all_off,
    output logic [NUM_BITS*NUM_CHANNELS-1:0]     carrier_out,
    output logic [NUM_BITS*NUM_CHANNELS-1:0]     modulator_out,
    output logic [NUM_CHANNELS-1:0]              available,
    output logic                                 drop,
    output logic [$clog2(NUM_CHANNELS+1)-1:0]    active_cnt
);

    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W = $clog2(NUM_CHANNELS + 1);
    localparam int EN    = NUM_BITS - 1;   // note-enable bit of a carrier word

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_WRITE  = 2'd2
    } state_e;

    // Control state
    state_e                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   cap_en;

    // Captured event
    logic                   on_q;
    logic [KEY_BITS-1:0]    key_q;
    logic [NUM_BITS-2:0]    car_q;
    logic [NUM_BITS-1:0]    mod_q;

    // Channel decision made in SEARCH, consumed in WRITE
    logic                   hit_q, hit_d;     // a channel is to be written
    logic                   full_q, full_d;   // note-on found every channel busy
    logic [CH_W-1:0]        tgt_q, tgt_d;

    // Banks and bookkeeping
    logic [NUM_CHANNELS-1:0][NUM_BITS-1:0] car_bank_q, car_bank_d;
    logic [NUM_CHANNELS-1:0][NUM_BITS-1:0] mod_bank_q, mod_bank_d;
    logic [NUM_CHANNELS-1:0][KEY_BITS-1:0] key_tab_q, key_tab_d;
    logic [NUM_CHANNELS-1:0]               avail_q, avail_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic                                  drop_q, drop_d;

    // Search helpers
    logic                   match_found, free_found;
    logic [CH_W-1:0]        match_ch, free_ch;

`ifdef VOICE_STEAL_EN
    logic [CH_W-1:0]        rr_q, rr_d;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign carrier_out   = car_bank_q;
    assign modulator_out = mod_bank_q;
    assign available     = avail_q;
    assign active_cnt    = cnt_q;
    assign drop          = drop_q;
    // Panic masks the registered ready so no event slips in while it is held.
    assign evt_ready     = ready_q & ~all_off;

    // -----------------------------------------------------------------------
    // Next-state and handshake logic for the IDLE/SEARCH/WRITE sequence
    // -----------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (evt_valid && evt_ready) begin
                    cap_en  = 1'b1;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: state_d = S_WRITE;
            S_WRITE:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Panic aborts any in-flight event.
        if (all_off) begin
            state_d = S_IDLE;
            cap_en  = 1'b0;
        end
        // Ready is registered: it reflects the state being entered.
        ready_d = (state_d == S_IDLE);
    end

    // -----------------------------------------------------------------------
    // Channel search: lowest-index enabled key match and lowest free channel
    // -----------------------------------------------------------------------
    always_comb begin
        match_found = 1'b0;
        match_ch    = '0;
        free_found  = 1'b0;
        free_ch     = '0;
        // Descending scan so the lowest index is the last (winning) assignment.
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (car_bank_q[i][EN] && (key_tab_q[i] == key_q)) begin
                match_found = 1'b1;
                match_ch    = CH_W'(i);
            end
            if (avail_q[i]) begin
                free_found = 1'b1;
                free_ch    = CH_W'(i);
            end
        end

        hit_d  = 1'b0;
        full_d = 1'b0;
        tgt_d  = '0;
        if (on_q) begin
            if (match_found) begin
                hit_d = 1'b1;
                tgt_d = match_ch;
            end else if (free_found) begin
                hit_d = 1'b1;
                tgt_d = free_ch;
            end else begin
                full_d = 1'b1;
`ifdef VOICE_STEAL_EN
                hit_d  = 1'b1;
                tgt_d  = rr_q;
`endif
            end
        end else if (match_found) begin
            hit_d = 1'b1;
            tgt_d = match_ch;
        end
    end

    // -----------------------------------------------------------------------
    // Bank, key table, availability, count and drop updates
    // -----------------------------------------------------------------------
    always_comb begin
        car_bank_d = car_bank_q;
        mod_bank_d = mod_bank_q;
        key_tab_d  = key_tab_q;
        avail_d    = avail_q;
        drop_d     = 1'b0;
`ifdef VOICE_STEAL_EN
        rr_d       = rr_q;
`endif

        if (all_off) begin
            // Silence everything but keep the phase increments.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                car_bank_d[i][EN] = 1'b0;
                mod_bank_d[i]     = '0;
            end
            avail_d = '1;
        end else if (state_q == S_WRITE) begin
            drop_d = full_q;
            if (hit_q) begin
                if (on_q) begin
                    car_bank_d[tgt_q] = {1'b1, car_q};
                    mod_bank_d[tgt_q] = mod_q;
                    key_tab_d[tgt_q]  = key_q;
                    avail_d[tgt_q]    = 1'b0;
                end else begin
                    car_bank_d[tgt_q][EN] = 1'b0;
                    mod_bank_d[tgt_q]     = '0;
                    avail_d[tgt_q]        = 1'b1;
                end
            end
`ifdef VOICE_STEAL_EN
            if (full_q) begin
                rr_d = (rr_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : rr_q + 1'b1;
            end
`endif
        end

        // Count follows the next availability so both change on one edge.
        cnt_d = CNT_W'(NUM_CHANNELS);
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cnt_d = cnt_d - CNT_W'(avail_d[i]);
        end
    end

    // -----------------------------------------------------------------------
    // State, capture, decision and bank registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            on_q       <= 1'b0;
            key_q      <= '0;
            car_q      <= '0;
            mod_q      <= '0;
            hit_q      <= 1'b0;
            full_q     <= 1'b0;
            tgt_q      <= '0;
            car_bank_q <= '0;
            mod_bank_q <= '0;
            // NOTE: the key table is a small register file that must read as
            // zero after reset, so it is built from resettable flops, not RAM.
            key_tab_q  <= '0;
            avail_q    <= '1;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            if (cap_en) begin
                on_q  <= evt_on;
                key_q <= evt_key;
                car_q <= evt_car;
                mod_q <= evt_mod;
            end
            hit_q      <= hit_d;
            full_q     <= full_d;
            tgt_q      <= tgt_d;
            car_bank_q <= car_bank_d;
            mod_bank_q <= mod_bank_d;
            key_tab_q  <= key_tab_d;
            avail_q    <= avail_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
        end
    end

`ifdef VOICE_STEAL_EN
    // Round-robin steal pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// ---------------------------------------------------------------------------
// tb_voice_allocator
//   Table-driven bench for voice_allocator. Each event record carries its
//   expected channel and bookkeeping; records are queued when driven and
//   popped when the commit becomes visible two edges after acceptance.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_voice_allocator;

    localparam int NB = 32;
    localparam int NC = 16;
    localparam int KB = 7;
    localparam int CW = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               evt_valid = 1'b0;
    logic               evt_ready;
    logic               evt_on = 1'b0;
    logic [KB-1:0]      evt_key = '0;
    logic [NB-2:0]      evt_car = '0;
    logic [NB-1:0]      evt_mod = '0;
    logic               all_off = 1'b0;
    logic [NB*NC-1:0]   carrier_out;
    logic [NB*NC-1:0]   modulator_out;
    logic [NC-1:0]      available;
    logic               drop;
    logic [CW-1:0]      active_cnt;

    always #5 clk = ~clk;

    voice_allocator #(
        .NUM_BITS    (NB),
        .NUM_CHANNELS(NC),
        .KEY_BITS    (KB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_on       (evt_on),
        .evt_key      (evt_key),
        .evt_car      (evt_car),
        .evt_mod      (evt_mod),
        .all_off      (all_off),
        .carrier_out  (carrier_out),
        .modulator_out(modulator_out),
        .available    (available),
        .drop         (drop),
        .active_cnt   (active_cnt)
    );

    typedef struct {
        logic          on;
        logic [KB-1:0] key;
        logic [NB-2:0] car;
        logic [NB-1:0] mod;
        int            ch;      // expected channel written, -1 = no bank change
        logic [NC-1:0] avail;
        logic [CW-1:0] cnt;
        logic          drop;
    } vec_t;

    vec_t        sb_q[$];
    logic [NB-1:0] exp_car [NC];
    logic [NB-1:0] exp_mod [NC];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NB*NC-1:0] pack_car();
        logic [NB*NC-1:0] v;
        for (int i = 0; i < NC; i++) v[i*NB +: NB] = exp_car[i];
        return v;
    endfunction

    function automatic logic [NB*NC-1:0] pack_mod();
        logic [NB*NC-1:0] v;
        for (int i = 0; i < NC; i++) v[i*NB +: NB] = exp_mod[i];
        return v;
    endfunction

    task automatic clear_shadow();
        for (int i = 0; i < NC; i++) begin
            exp_car[i] = '0;
            exp_mod[i] = '0;
        end
    endtask

    task automatic check_banks(input string tag, input logic [NC-1:0] av, input logic [CW-1:0] cnt);
        check({tag, "_carrier"}, carrier_out, pack_car());
        check({tag, "_modulator"}, modulator_out, pack_mod());
        check({tag, "_available"}, available, av);
        check({tag, "_active_cnt"}, active_cnt, cnt);
    endtask

    // Bounded wait for the handshake to open; called on a falling edge.
    task automatic wait_ready();
        int n = 0;
        while (evt_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (evt_ready !== 1'b1) check("ready_timeout", evt_ready, 1);
    endtask

    // Drive one event, queue its expectation, then pop and compare on commit.
    task automatic send(input vec_t v);
        vec_t e;
        wait_ready();
        evt_valid = 1'b1;
        evt_on    = v.on;
        evt_key   = v.key;
        evt_car   = v.car;
        evt_mod   = v.mod;
        sb_q.push_back(v);
        @(posedge clk);                 // accept edge E
        @(negedge clk);
        evt_valid = 1'b0;
        evt_car   = 31'h7FFF_FFFF;      // scramble: captured copy must be used
        evt_mod   = 32'hFFFF_FFFF;
        check("ready_after_accept", evt_ready, 0);
        @(negedge clk);                 // E+1.5: nothing committed yet
        check("drop_early", drop, 0);
        check("ready_search", evt_ready, 0);
        @(negedge clk);                 // E+2.5: commit visible
        e = sb_q.pop_front();
        if (e.ch >= 0) begin
            if (e.on) begin
                exp_car[e.ch] = {1'b1, e.car};
                exp_mod[e.ch] = e.mod;
            end else begin
                exp_car[e.ch][NB-1] = 1'b0;
                exp_mod[e.ch]       = '0;
            end
        end
        check_banks($sformatf("evt_key%0d", e.key), e.avail, e.cnt);
        check("drop_commit", drop, e.drop);
        check("ready_reopen", evt_ready, 1);
        @(negedge clk);                 // E+3.5: drop is a single-cycle pulse
        check("drop_pulse_end", drop, 0);
    endtask

    task automatic pulse_all_off();
        all_off = 1'b1;
        #1;
        check("ready_during_all_off", evt_ready, 0);
        @(negedge clk);
        all_off = 1'b0;
        #1;
        for (int i = 0; i < NC; i++) begin
            exp_car[i][NB-1] = 1'b0;
            exp_mod[i]       = '0;
        end
        check_banks("all_off", '1, '0);
        check("ready_after_all_off", evt_ready, 1);
    endtask

    vec_t tbl [11];
    vec_t v;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed sequence of events starting from reset; each row is
        // {on, key, car, mod, expected channel, available, active_cnt, drop}.
        tbl[0]  = '{1'b1, 7'd60, 31'h100, 32'h80, 0,  16'hFFFE, 5'd1, 1'b0};
        tbl[1]  = '{1'b1, 7'd62, 31'h200, 32'h11, 1,  16'hFFFC, 5'd2, 1'b0};
        tbl[2]  = '{1'b1, 7'd64, 31'h300, 32'h22, 2,  16'hFFF8, 5'd3, 1'b0};
        tbl[3]  = '{1'b0, 7'd62, 31'h7ABC, 32'h99, 1, 16'hFFFA, 5'd2, 1'b0};
        tbl[4]  = '{1'b1, 7'd65, 31'h400, 32'h33, 1,  16'hFFF8, 5'd3, 1'b0};
        tbl[5]  = '{1'b1, 7'd60, 31'h555, 32'h44, 0,  16'hFFF8, 5'd3, 1'b0};
        tbl[6]  = '{1'b0, 7'd99, 31'h0,   32'h0,  -1, 16'hFFF8, 5'd3, 1'b0};
        tbl[7]  = '{1'b0, 7'd60, 31'h0,   32'h0,  0,  16'hFFF9, 5'd2, 1'b0};
        tbl[8]  = '{1'b0, 7'd60, 31'h0,   32'h0,  -1, 16'hFFF9, 5'd2, 1'b0};
        tbl[9]  = '{1'b1, 7'd0,  31'h1,   32'h1,  0,  16'hFFF8, 5'd3, 1'b0};
        tbl[10] = '{1'b0, 7'd0,  31'h0,   32'h0,  0,  16'hFFF9, 5'd2, 1'b0};

        clear_shadow();

        // Reset state and release.
        repeat (3) @(negedge clk);
        check_banks("in_reset", '1, '0);
        check("drop_in_reset", drop, 0);
        check("ready_in_reset", evt_ready, 0);
        rst_n = 1'b1;
        #1;
        check("ready_first_cycle", evt_ready, 0);
        @(negedge clk);
        check("ready_after_release", evt_ready, 1);
        check_banks("post_reset", '1, '0);

        // Table-driven allocation, note-off, retrigger and no-match cases.
        for (int i = 0; i < 11; i++) send(tbl[i]);

        // Panic from idle: enables and modulators cleared, increments kept.
        pulse_all_off();

        // Same key twice: one channel, second value wins.
        v = '{1'b1, 7'd60, 31'h10, 32'h1, 0, 16'hFFFE, 5'd1, 1'b0};
        send(v);
        v = '{1'b1, 7'd60, 31'h20, 32'h2, 0, 16'hFFFE, 5'd1, 1'b0};
        send(v);

        // Fill the remaining fifteen channels.
        for (int i = 1; i < NC; i++) begin
            v.on    = 1'b1;
            v.key   = 7'(100 + i);
            v.car   = 31'(32'h1000 + i);
            v.mod   = 32'(i);
            v.ch    = i;
            v.avail = 16'hFFFF << (i + 1);
            v.cnt   = 5'(i + 1);
            v.drop  = 1'b0;
            send(v);
        end

        // Note-on with every channel busy.
`ifdef VOICE_STEAL_EN
        v = '{1'b1, 7'd70, 31'h777, 32'h77, 0, 16'h0000, 5'd16, 1'b1};
        send(v);
        v = '{1'b1, 7'd71, 31'h778, 32'h78, 1, 16'h0000, 5'd16, 1'b1};
        send(v);
`else
        v = '{1'b1, 7'd70, 31'h777, 32'h77, -1, 16'h0000, 5'd16, 1'b1};
        send(v);
`endif

        pulse_all_off();

        // Panic while a note-on sits in SEARCH: event must not be committed.
        wait_ready();
        evt_valid = 1'b1;
        evt_on    = 1'b1;
        evt_key   = 7'd50;
        evt_car   = 31'h123;
        evt_mod   = 32'h9;
        @(posedge clk);
        @(negedge clk);
        evt_valid = 1'b0;
        pulse_all_off();
        @(negedge clk);
        check_banks("no_commit", '1, '0);
        check("drop_no_commit", drop, 0);

        // Allocator still works after the aborted event.
        v = '{1'b1, 7'd50, 31'h123, 32'h9, 0, 16'hFFFE, 5'd1, 1'b0};
        send(v);

        // Asynchronous reset with an event in flight.
        wait_ready();
        evt_valid = 1'b1;
        evt_on    = 1'b1;
        evt_key   = 7'd10;
        evt_car   = 31'h42;
        evt_mod   = 32'h5;
        @(posedge clk);
        @(negedge clk);
        evt_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        clear_shadow();
        check_banks("async_reset", '1, '0);
        check("ready_async_reset", evt_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_rerelease", evt_ready, 0);
        @(negedge clk);
        check("ready_rerelease_up", evt_ready, 1);
        repeat (2) @(negedge clk);
        check_banks("lost_event", '1, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
